// File: rtl/rc_pkg.sv
// Shared reservoir-computer package: FSM state type, accumulator sizing and default parameters.
package rc_pkg;

  localparam int unsigned RC_N_NEURONS   = 20;
  localparam int unsigned RC_STATE_W     = 16;
  localparam int unsigned RC_WEIGHT_W    = 8;
  localparam int unsigned RC_OUT_W       = 16;
  localparam int unsigned RC_SHIFT       = 8;
  localparam int unsigned RC_EVAL_CYCLES = 65535;
  localparam int unsigned RC_ADDR_W      = 13;
  localparam int unsigned RC_ROM_DEPTH   = 8192;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_MAC     = 2'd2,
    ST_HOLD    = 2'd3
  } rc_state_e;

  // Sum of N products of sw x ww bits never exceeds this width.
  function automatic int unsigned acc_w(input int unsigned sw, input int unsigned ww,
                                        input int unsigned n);
    return sw + ww + $clog2(n);
  endfunction

  localparam int unsigned RC_ACC_W = acc_w(RC_STATE_W, RC_WEIGHT_W, RC_N_NEURONS);

endpackage

// File: rtl/rc_mac_unit.sv
// Registered multiply-accumulate with clear/enable and a shift + wrap/saturate result stage.
// Build macro RC_READOUT_SAT_EN selects saturation; default takes the low OUT_W bits.
module rc_mac_unit #(
  parameter int unsigned A_W   = 16,
  parameter int unsigned B_W   = 8,
  parameter int unsigned ACC_W = 29,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  output logic [OUT_W-1:0] res_o
);

  localparam int unsigned PROD_W = A_W + B_W;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_q, acc_d, shifted;
  logic [OUT_W-1:0]  res_q, res_d;

  always_comb begin
    prod    = PROD_W'(a_i) * PROD_W'(b_i);
    acc_d   = acc_q + ACC_W'(prod);
    shifted = acc_d >> SHIFT;
  end

`ifdef RC_READOUT_SAT_EN
  localparam int unsigned EXT_W = ACC_W + OUT_W;
  localparam logic [OUT_W-1:0] OUT_MAX = '1;
  assign res_d = (EXT_W'(shifted) > EXT_W'(OUT_MAX)) ? '1 : OUT_W'(shifted);
`else
  assign res_d = OUT_W'(shifted);
`endif

  // The result register tracks the running sum so it is final on the last MAC edge.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      acc_q <= '0;
      res_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/rc_readout_engine.sv
// Per-period input sample scheduling (ROM or external) and sequential weighted-sum readout.
// Build macro RC_READOUT_SAT_EN: saturate the readout instead of wrapping it.
module rc_readout_engine
  import rc_pkg::*;
#(
  parameter int unsigned N_NEURONS   = RC_N_NEURONS,
  parameter int unsigned STATE_W     = RC_STATE_W,
  parameter int unsigned WEIGHT_W    = RC_WEIGHT_W,
  parameter int unsigned OUT_W       = RC_OUT_W,
  parameter int unsigned SHIFT       = RC_SHIFT,
  parameter int unsigned EVAL_CYCLES = RC_EVAL_CYCLES,
  parameter int unsigned ADDR_W      = RC_ADDR_W,
  parameter int unsigned ROM_DEPTH   = RC_ROM_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         data_sel,
  input  logic                         training,
  input  logic [STATE_W-1:0]           ext_data,
  input  logic                         ext_valid,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [STATE_W-1:0]           rom_data,
  output logic [STATE_W-1:0]           x_out,
  output logic                         x_valid,
  input  logic [N_NEURONS*STATE_W-1:0] state_in,
  input  logic                         w_we,
  input  logic [5:0]                   w_idx,
  input  logic [WEIGHT_W-1:0]          w_data,
  output logic                         w_ready,
  output logic [OUT_W-1:0]             y_out,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic                         overrun
);

  localparam int unsigned CNT_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam int unsigned IDX_W = $clog2(N_NEURONS);
  localparam int unsigned ACC_W = acc_w(STATE_W, WEIGHT_W, N_NEURONS);

  rc_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic [STATE_W-1:0] sample_q, x_out_q;
  logic               x_valid_q;
  logic [STATE_W-1:0] snap_q [N_NEURONS];
  logic [WEIGHT_W-1:0] w_q   [N_NEURONS];
  logic [IDX_W-1:0]   idx_q;
  logic               y_valid_q, overrun_q, w_ready_q;
  logic               tick_c, w_wr_c;

  assign tick_c = (cnt_q == CNT_W'(EVAL_CYCLES - 1));
  assign w_wr_c = w_we && w_ready_q && (32'(w_idx) < N_NEURONS);

  // Evaluation period counter and input sample sourcing.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      rom_addr_q <= '0;
      sample_q   <= '0;
      x_out_q    <= '0;
      x_valid_q  <= 1'b0;
    end else begin
      cnt_q     <= tick_c ? '0 : cnt_q + CNT_W'(1);
      x_valid_q <= tick_c;
      if (ext_valid) sample_q <= ext_data;
      if (tick_c) begin
        x_out_q <= data_sel ? rom_data : sample_q;
        if (data_sel) begin
          rom_addr_q <= (rom_addr_q == ADDR_W'(ROM_DEPTH - 1)) ? '0 : rom_addr_q + ADDR_W'(1);
        end
      end
    end
  end

  // Weight register file and neuron state snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        w_q[i]    <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        if (w_wr_c && (w_idx == 6'(i))) w_q[i] <= w_data;
        if (state_q == ST_CAPTURE) snap_q[i] <= state_in[i*STATE_W +: STATE_W];
      end
    end
  end

  // Readout sequencer; a tick outside IDLE drops that period's readout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      w_ready_q <= 1'b1;
    end else begin
      if (tick_c && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (tick_c && !training) begin
            state_q   <= ST_CAPTURE;
            w_ready_q <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          state_q <= ST_MAC;
          idx_q   <= '0;
        end
        ST_MAC: begin
          if (idx_q == IDX_W'(N_NEURONS - 1)) begin
            state_q   <= ST_HOLD;
            y_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_HOLD: begin
          if (y_ready) begin
            state_q   <= ST_IDLE;
            y_valid_q <= 1'b0;
            w_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  rc_mac_unit #(
    .A_W  (STATE_W),
    .B_W  (WEIGHT_W),
    .ACC_W(ACC_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr_i(state_q == ST_CAPTURE),
    .en_i (state_q == ST_MAC),
    .a_i  (snap_q[idx_q]),
    .b_i  (w_q[idx_q]),
    .res_o(y_out)
  );

  assign rom_addr = rom_addr_q;
  assign x_out    = x_out_q;
  assign x_valid  = x_valid_q;
  assign w_ready  = w_ready_q;
  assign y_valid  = y_valid_q;
  assign overrun  = overrun_q;

endmodule
